// File: rtl/mac_pkg.sv
// Shared MAC-row types: result word, index-tagged result, row constants.
// Used by the collector and by the downstream write-back/accumulate stage.
package mac_pkg;

  localparam int MAC_OUTPUT_WIDTH = 32;
  localparam int MAC_NUM_UNITS    = 4;
  localparam int MAC_FIFO_DEPTH   = 8;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int MAC_IDX_WIDTH = idx_width(MAC_NUM_UNITS);

  typedef logic [MAC_OUTPUT_WIDTH-1:0] mac_result_t;

  typedef struct packed {
    logic [MAC_IDX_WIDTH-1:0] idx;
    mac_result_t              data;
  } mac_tagged_t;

endpackage

// File: rtl/mac_result_collector_if.sv
// Result stream from the collector to the consumer (valid/ready).
// master: out_valid/out_data/out_idx out, out_ready in; slave: mirrored.
interface mac_result_collector_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 2
);

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;

  modport master (
    output out_valid,
    output out_data,
    output out_idx,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_idx,
    output out_ready
  );

endinterface

// File: rtl/result_fifo.sv
// First-word-fall-through FIFO; async reset plus sync flush.
// Ports: push/push_data, pop/pop_data, full, empty, count.
module result_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves the same cycle.
  assign do_push = push && (!full || do_pop);
  // Storage is not cleared, so mask the head while empty.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case (1'b1)
        do_push && !do_pop: count <= count + CW'(1);
        do_pop && !do_push: count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mac_result_collector.sv
// Captures each MAC unit's result the cycle after its data_ready pulse,
// tags it with the unit index and queues it. Ports: clk, rst, flush,
// unit_ready, unit_result, out_if (result stream), fifo_count, overflow.
module mac_result_collector
  import mac_pkg::*;
#(
  parameter int NUM_UNITS    = MAC_NUM_UNITS,
  parameter int OUTPUT_WIDTH = MAC_OUTPUT_WIDTH,
  parameter int FIFO_DEPTH   = MAC_FIFO_DEPTH,
  parameter int IDX_WIDTH    = idx_width(NUM_UNITS)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic [NUM_UNITS-1:0]                  unit_ready,
  input  logic [NUM_UNITS-1:0][OUTPUT_WIDTH-1:0] unit_result,
  mac_result_collector_if.master                out_if,
  output logic [$clog2(FIFO_DEPTH):0]           fifo_count,
  output logic                                  overflow
);

  localparam int TW = IDX_WIDTH + OUTPUT_WIDTH;

  logic [NUM_UNITS-1:0]                   arm;
  logic [NUM_UNITS-1:0]                   pend;
  logic [NUM_UNITS-1:0]                   pend_nxt;
  logic [NUM_UNITS-1:0][OUTPUT_WIDTH-1:0] hold;

  logic                 sel_vld;
  logic [IDX_WIDTH-1:0] sel_idx;
  logic                 push_en;
  logic                 pop;
  logic                 ovf_hit;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [TW-1:0]        fifo_dout;

  assign out_if.out_valid = !fifo_empty;
  assign pop = !fifo_empty && out_if.out_ready;
  assign push_en = sel_vld && (!fifo_full || pop);
  assign {out_if.out_idx, out_if.out_data} = fifo_dout;

  // Lowest pending index wins.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (pend[i]) begin
        sel_vld = 1'b1;
        sel_idx = IDX_WIDTH'(i);
      end
    end
  end

  // A capture landing on the unit being pushed re-arms pend and is not
  // a loss; landing on any other still-pending unit is.
  always_comb begin
    pend_nxt = pend;
    ovf_hit  = 1'b0;
    if (push_en) pend_nxt[sel_idx] = 1'b0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (arm[i]) begin
        pend_nxt[i] = 1'b1;
        if (pend[i] && !(push_en && sel_idx == IDX_WIDTH'(i)))
          ovf_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm      <= '0;
      pend     <= '0;
      hold     <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      arm      <= '0;
      pend     <= '0;
      hold     <= '0;
      overflow <= 1'b0;
    end else begin
      // result_r is valid one cycle after data_ready.
      arm  <= unit_ready;
      pend <= pend_nxt;
      if (ovf_hit) overflow <= 1'b1;
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (arm[i]) hold[i] <= unit_result[i];
      end
    end
  end

  result_fifo #(
    .WIDTH (TW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push_en),
    .push_data ({sel_idx, hold[sel_idx]}),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_mac_result_collector.sv
// Bench for mac_result_collector: directed scenarios plus random
// traffic against a queue-based transaction model.
module tb_mac_result_collector;
  import mac_pkg::*;

  localparam int NU = 4;
  localparam int OW = 32;
  localparam int FD = 8;
  localparam int IW = 2;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic [NU-1:0] unit_ready = '0;
  logic [NU-1:0][OW-1:0] unit_result = '0;
  logic [CW-1:0] fifo_count;
  logic overflow;

  mac_result_collector_if #(.DATA_W(OW), .IDX_W(IW)) out_if ();

  mac_result_collector #(
    .NUM_UNITS(NU), .OUTPUT_WIDTH(OW),
    .FIFO_DEPTH(FD), .IDX_WIDTH(IW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .unit_ready(unit_ready), .unit_result(unit_result),
    .out_if(out_if), .fifo_count(fifo_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction model: latest unconsumed value per unit, plus an
  // ordered queue standing for the output FIFO.
  bit [NU-1:0]   m_arm;
  bit [NU-1:0]   m_pend;
  logic [OW-1:0] m_hold [NU];
  mac_tagged_t   m_q[$];
  bit            m_ovf;

  task automatic m_clear();
    m_arm  = '0;
    m_pend = '0;
    m_q.delete();
    m_ovf  = 1'b0;
  endtask

  task automatic m_step();
    bit pop, push;
    int sel;
    mac_tagged_t t;
    pop = (m_q.size() > 0) && (out_if.out_ready === 1'b1);
    sel = -1;
    for (int i = NU - 1; i >= 0; i--)
      if (m_pend[i]) sel = i;
    push = (sel >= 0) && (m_q.size() < FD || pop);
    if (pop) void'(m_q.pop_front());
    if (push) begin
      t.idx  = IW'(sel);
      t.data = m_hold[sel];
      m_q.push_back(t);
      m_pend[sel] = 1'b0;
    end
    for (int i = 0; i < NU; i++) begin
      if (m_arm[i]) begin
        if (m_pend[i]) m_ovf = 1'b1;
        m_hold[i] = unit_result[i];
        m_pend[i] = 1'b1;
      end
    end
    m_arm = unit_ready;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst || flush) m_clear();
    else m_step();
  end

  task automatic check_outputs();
    bit v;
    v = (m_q.size() != 0);
    chk("valid", 64'(out_if.out_valid), 64'(v));
    if (v) begin
      chk("data", 64'(out_if.out_data), 64'(m_q[0].data));
      chk("idx", 64'(out_if.out_idx), 64'(m_q[0].idx));
    end
    chk("count", 64'(fifo_count), 64'(m_q.size()));
    chk("ovf", 64'(overflow), 64'(m_ovf));
  endtask

  mac_tagged_t seen[$];
  mac_tagged_t exp_q[$];

  function automatic mac_tagged_t mk(input int idx, input int data);
    mac_tagged_t t;
    t.idx  = IW'(idx);
    t.data = OW'(data);
    return t;
  endfunction

  // Called just after a negedge: drive one cycle, sample at next negedge.
  task automatic cyc(input logic [NU-1:0] rdy,
                     input logic ordy,
                     input logic fl);
    unit_ready = rdy;
    out_if.out_ready = ordy;
    flush = fl;
    if (!rst && !fl && out_if.out_valid && ordy)
      seen.push_back(mac_tagged_t'({out_if.out_idx, out_if.out_data}));
    @(negedge clk);
    check_outputs();
  endtask

  task automatic rnd_results();
    for (int i = 0; i < NU; i++) unit_result[i] = $urandom;
  endtask

  task automatic expect_seen(input string tag);
    chk({tag, "_n"}, 64'(seen.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < seen.size()) chk(tag, 64'(seen[i]), 64'(exp_q[i]));
  endtask

  initial begin
    m_clear();
    out_if.out_ready = 1'b0;
    #1;
    chk("rst_valid", 64'(out_if.out_valid), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_data", 64'(out_if.out_data), 64'd0);
    chk("rst_idx", 64'(out_if.out_idx), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) cyc('0, 1'b1, 1'b0);

    // Single pulse, three-cycle latency.
    seen.delete();
    cyc(4'b0100, 1'b1, 1'b0);
    unit_result[2] = 32'h0000_1234;
    cyc('0, 1'b1, 1'b0);
    chk("sp_v_t2", 64'(out_if.out_valid), 64'd0);
    cyc('0, 1'b1, 1'b0);
    chk("sp_v_t3", 64'(out_if.out_valid), 64'd1);
    chk("sp_data", 64'(out_if.out_data), 64'h1234);
    chk("sp_idx", 64'(out_if.out_idx), 64'd2);
    cyc('0, 1'b1, 1'b0);
    chk("sp_v_t4", 64'(out_if.out_valid), 64'd0);
    exp_q = '{mk(2, 32'h1234)};
    expect_seen("sp");

    // Staggered chain.
    seen.delete();
    cyc(4'b0001, 1'b1, 1'b0);
    unit_result[0] = 11; cyc(4'b0010, 1'b1, 1'b0);
    unit_result[1] = 22; cyc(4'b0100, 1'b1, 1'b0);
    unit_result[2] = 33; cyc(4'b1000, 1'b1, 1'b0);
    unit_result[3] = 44; cyc('0, 1'b1, 1'b0);
    repeat (6) cyc('0, 1'b1, 1'b0);
    exp_q = '{mk(0, 11), mk(1, 22), mk(2, 33), mk(3, 44)};
    expect_seen("chain");
    chk("chain_ovf", 64'(overflow), 64'd0);

    // Simultaneous pulses.
    seen.delete();
    cyc(4'b1001, 1'b1, 1'b0);
    unit_result[0] = 7;
    unit_result[3] = 9;
    cyc('0, 1'b1, 1'b0);
    repeat (5) cyc('0, 1'b1, 1'b0);
    exp_q = '{mk(0, 7), mk(3, 9)};
    expect_seen("simul");

    // Backpressure: 10 results, 8 in FIFO, 2 held pending.
    seen.delete();
    exp_q.delete();
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) unit_result[(k-1)%4] = 100 + k - 1;
      cyc((k < 10) ? NU'(1 << (k % 4)) : NU'(0), 1'b0, 1'b0);
    end
    repeat (3) cyc('0, 1'b0, 1'b0);
    chk("bp_count", 64'(fifo_count), 64'd8);
    repeat (14) cyc('0, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) exp_q.push_back(mk(k % 4, 100 + k));
    expect_seen("bp");
    chk("bp_ovf", 64'(overflow), 64'd0);

    // Overflow on unit 1 while FIFO is full.
    seen.delete();
    exp_q.delete();
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) unit_result[(k-1)%4] = 200 + k - 1;
      cyc((k < 8) ? NU'(1 << (k % 4)) : NU'(0), 1'b0, 1'b0);
    end
    repeat (2) cyc('0, 1'b0, 1'b0);
    cyc(4'b0010, 1'b0, 1'b0);
    unit_result[1] = 5; cyc('0, 1'b0, 1'b0);
    cyc(4'b0010, 1'b0, 1'b0);
    unit_result[1] = 6; cyc('0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0);
    chk("ov_flag", 64'(overflow), 64'd1);
    repeat (12) cyc('0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) exp_q.push_back(mk(k % 4, 200 + k));
    exp_q.push_back(mk(1, 6));
    expect_seen("ov");
    cyc(4'b0001, 1'b0, 1'b0);
    repeat (3) cyc('0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b1);
    chk("fl_ovf", 64'(overflow), 64'd0);
    chk("fl_count", 64'(fifo_count), 64'd0);

    // Asynchronous reset with three entries queued.
    cyc(4'b0111, 1'b0, 1'b0);
    rnd_results();
    repeat (5) cyc('0, 1'b0, 1'b0);
    chk("pre_rst_count", 64'(fifo_count), 64'd3);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(out_if.out_valid), 64'd0);
    chk("arst_count", 64'(fifo_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen.delete();
    cyc('0, 1'b1, 1'b0);
    cyc(4'b1000, 1'b1, 1'b0);
    unit_result[3] = 32'hCAFE_0001;
    cyc('0, 1'b1, 1'b0);
    repeat (4) cyc('0, 1'b1, 1'b0);
    exp_q = '{mk(3, 32'hCAFE_0001)};
    expect_seen("post_rst");

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [NU-1:0] r;
      for (int i = 0; i < NU; i++) r[i] = ($urandom % 4) == 0;
      rnd_results();
      cyc(r, ($urandom % 10) < 6, ($urandom % 80) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mac_result_collector.md
Name: mac_result_collector

Overview:
- Sits directly downstream of a row of NUM_UNITS MAC units.
- Watches each unit's one-cycle data_ready pulse and captures that unit's result_r on the following cycle.
- Serialises captured results, tagged with the unit index, into a FIFO.
- Drains the FIFO over a valid/ready stream to the write-back or accumulate stage.

Parameters:
- NUM_UNITS, 4, number of MAC units in the row.
- OUTPUT_WIDTH, 32, width of each MAC result.
- FIFO_DEPTH, 8, output FIFO entries; power of two, at least 2.
- IDX_WIDTH, $clog2(NUM_UNITS) (minimum 1), width of the unit index tag.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  synchronous clear of all collector state.
- unit_ready  in  NUM_UNITS  data_ready pulses, one bit per unit.
- unit_result  in  NUM_UNITS x OUTPUT_WIDTH  result_r of each unit.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head.
- out_data  out  OUTPUT_WIDTH  head result.
- out_idx  out  IDX_WIDTH  unit index of the head result.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- overflow  out  1  sticky: a pending result was overwritten.

Behaviour:
- Reset: while rst=1, all of the following are 0: arm, pend, hold registers, FIFO pointers, out_valid, fifo_count, overflow. out_data and out_idx are 0.
- flush=1: same clear as reset at the clock edge. flush takes priority over every event in that cycle.
- Capture timing (unit result_r updates on the edge that ends its data_ready cycle):
  - Cycle t: unit_ready[i]=1. At the edge, arm[i] <= 1.
  - Cycle t+1: arm[i]=1 and unit_result[i] is valid. At the edge, hold[i] <= unit_result[i], pend[i] <= 1, arm[i] <= 0 (unless unit_ready[i] is 1 again, in which case arm[i] stays 1).
- Arbiter: each cycle selects the lowest index i with pend[i]=1.
  - Push when a selection exists and (FIFO not full, or full with a pop in the same cycle).
  - On push: FIFO gets {i, hold[i]} and pend[i] clears. Exactly one push per cycle at most.
- Latency: data_ready pulse in cycle t with an empty FIFO gives out_valid=1 in cycle t+3.
- Simultaneous capture and arbitration on the same unit: the new capture wins. pend[i] stays 1, hold[i] takes the new value, the old value is pushed, and overflow is not set.
- Overflow: arm[i]=1 while pend[i]=1 and unit i is not being pushed this cycle. The new value overwrites hold[i] and overflow <= 1. overflow clears only on rst or flush.
- FIFO:
  - First-word-fall-through; out_data and out_idx are valid whenever out_valid=1.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle: fifo_count unchanged; when full, the push is accepted.
  - Pointers wrap modulo FIFO_DEPTH.
- Full FIFO without a pop: no push. pend bits are held, which provides backpressure into the holding registers only; there is no stall signal to the MAC row.
- Empty FIFO: out_valid=0 and out_ready is ignored.
- Reset mid-operation: in-flight arm/pend and FIFO contents are discarded. unit_ready pulses arriving in the cycle rst deasserts are captured normally.
- No arithmetic on results; data passes bit-exact.

Decomposition:
- Shared package mac_pkg:
  - Constants MAC_OUTPUT_WIDTH=32 and MAC_NUM_UNITS.
  - Typedef mac_result_t (logic [OUTPUT_WIDTH-1:0]).
  - Packed struct mac_tagged_t {idx, data}, used by this block and the downstream consumer.
- Sub-module result_fifo: parameterised width/depth FWFT synchronous FIFO with push, pop, full, empty and count; async active-high reset plus sync flush.
- Arbiter, arm/pend logic and holding registers stay in the top module.

Test Plan:
- Single pulse: unit_ready=4'b0100 in cycle 10, unit_result[2]=32'h0000_1234 in cycle 11, out_ready=1 -> out_valid=1 in cycle 13 with out_data=32'h1234, out_idx=2; out_valid=0 in cycle 14.
- Staggered chain: pulses on units 0..3 in cycles 20..23 with results 11,22,33,44 -> outputs 11,22,33,44 with idx 0..3 in cycles 23..26; overflow stays 0.
- Simultaneous: units 0 and 3 pulse in the same cycle with results 7 and 9 -> (idx 0, 7) then (idx 3, 9) on consecutive cycles.
- Backpressure: out_ready=0 and 10 results collected -> fifo_count reaches 8, remaining 2 results held in pend. Raise out_ready -> all 10 delivered in order, none lost, overflow=0.
- Overflow: out_ready=0, FIFO full, unit 1 pulses twice (results 5 then 6) -> overflow=1; after draining, idx 1 delivers 6 only. flush clears overflow and fifo_count to 0.
- Reset mid-operation: assert rst asynchronously with 3 entries queued -> out_valid=0 and fifo_count=0 immediately, without waiting for a clock edge. A pulse one cycle after release is delivered normally.
